dmem_port: RTL and testbench



---
 rtl/dmem_port.sv | 173 +++++++++++++++++
 tb/tb_dmem_port.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port.sv
// Memory-side responder for the core data-memory interface: valid/ready request,
// programmable wait states, read-modify-write sub-word stores, extended load data.
`timescale 1ns/1ps
module dmem_port #(
    parameter int ADDR_WIDTH  = 18,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCESS, S_MERGE, S_RESP} state_t;

    localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  we_q, we_d;
    logic [2:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [1:0]            lane_q, lane_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [31:0]           rdata_q, rdata_d;
    logic [31:0]           old_q, old_d;

    logic [31:0] mem [2**ADDR_WIDTH];
    logic [31:0] mem_rdata, mem_wdata, load_ext, merged, shifted, lane_mask;
    logic [15:0] half_sel;
    logic        mem_we, req_err;
    logic        unused_addr;

    // Upper address bits wrap around and are deliberately dropped.
    assign unused_addr = ^req_addr[31:ADDR_WIDTH+2];
    assign mem_rdata   = mem[idx_q];

    // Misaligned H/W, undefined size codes and unsigned-size stores are rejected.
    always_comb begin
        case (req_size)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = req_addr[0];
            3'b010:  req_err = |req_addr[1:0];
            3'b100:  req_err = req_we;
            3'b101:  req_err = req_we | req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    always_comb begin
        shifted   = mem_rdata >> {lane_q, 3'b000};
        half_sel  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_ext = {24'h0, shifted[7:0]};
            3'b101:  load_ext = {16'h0, half_sel};
            default: load_ext = mem_rdata;
        endcase
        lane_mask = size_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        merged    = (old_q & ~(lane_mask << {lane_q, 3'b000}))
                  | ((wdata_q & lane_mask) << {lane_q, 3'b000});
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        size_d    = size_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        rdata_d   = rdata_q;
        old_d     = old_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    idx_d   = req_addr[ADDR_WIDTH+1:2];
                    lane_d  = req_addr[1:0];
                    wdata_d = req_wdata;
                    err_d   = req_err;
                    rdata_d = '0;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) state_d = S_ACCESS;
                else             cnt_d   = cnt_q - 1'b1;
            end
            S_ACCESS: begin
                if (!we_q) begin
                    rdata_d = load_ext;
                    state_d = S_RESP;
                end else if (size_q[1:0] == 2'b10) begin
                    mem_we  = 1'b1;
                    state_d = S_RESP;
                end else begin
                    old_d   = mem_rdata;
                    state_d = S_MERGE;
                end
            end
            S_MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = merged;
                state_d   = S_RESP;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            size_q  <= '0;
            idx_q   <= '0;
            lane_q  <= '0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            old_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            size_q  <= size_d;
            idx_q   <= idx_d;
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            old_q   <= old_d;
        end
    end

    // NOTE: the array has no reset; a reset before the write edge simply drops mem_we.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx_q] <= mem_wdata;
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        resp_rdata = (state_q == S_RESP) ? rdata_q : 32'h0;
        resp_err   = (state_q == S_RESP) && err_q;
    end

endmodule

// File: tb/tb_dmem_port.sv
// Directed self-checking bench for dmem_port: a W=2 instance and a W=0 instance.
`timescale 1ns/1ps
module tb_dmem_port;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid0, req_we;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        req_ready, resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        req_ready0, resp_valid0, resp_err0;
    logic [31:0] resp_rdata0;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the last run_req transaction.
    int          r_lat, r_np;
    logic [31:0] r_data, r_after;
    logic        r_err;

    always #5 clk = ~clk;

    dmem_port #(.ADDR_WIDTH(18), .WAIT_STATES(2)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    dmem_port #(.ADDR_WIDTH(8), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
        .req_we(req_we), .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_rdata(resp_rdata0), .resp_err(resp_err0)
    );

    // Issue one request, then watch 12 cycles for response latency, data and pulse count.
    task automatic run_req(input bit sel0, input logic we, input logic [2:0] size,
                           input logic [31:0] addr, input logic [31:0] wdata);
        logic rv;
        logic [31:0] rd;
        @(negedge clk);
        req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
        if (sel0) req_valid0 = 1'b1; else req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0; req_valid0 = 1'b0;
        r_lat = -1; r_np = 0; r_data = 32'hFFFF_FFFF; r_err = 1'bx; r_after = 32'hFFFF_FFFF;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            rv = sel0 ? resp_valid0 : resp_valid;
            rd = sel0 ? resp_rdata0 : resp_rdata;
            if (rv) begin
                r_np++;
                if (r_lat < 0) begin
                    r_lat = c; r_data = rd; r_err = sel0 ? resp_err0 : resp_err;
                end
            end else if (r_lat > 0 && c == r_lat + 1) begin
                r_after = rd;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_valid0 = 1'b0;
        req_we = 1'b0; req_size = 3'b000; req_addr = '0; req_wdata = '0;
        #1;
        n_checks++; if ({req_ready, resp_valid, resp_err} !== 3'b100) begin n_fail++; $display("FAIL reset_flags: got %b exp 100", {req_ready, resp_valid, resp_err}); end
        n_checks++; if (resp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h exp 0", resp_rdata); end
        n_checks++; if ({req_ready0, resp_valid0, resp_err0} !== 3'b100) begin n_fail++; $display("FAIL reset_flags_w0: got %b exp 100", {req_ready0, resp_valid0, resp_err0}); end
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic test_word();
        run_req(0, 1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF);
        n_checks++; if (r_lat !== 4) begin n_fail++; $display("FAIL sw_latency: got %0d exp 4", r_lat); end
        n_checks++; if ({r_err, r_data} !== 33'h0) begin n_fail++; $display("FAIL sw_resp: got err %b data %h exp 0/0", r_err, r_data); end
        n_checks++; if (r_np !== 1) begin n_fail++; $display("FAIL sw_pulses: got %0d exp 1", r_np); end
        run_req(0, 1'b0, 3'b010, 32'h100, 32'h0);
        n_checks++; if (r_lat !== 4) begin n_fail++; $display("FAIL lw_latency: got %0d exp 4", r_lat); end
        n_checks++; if (r_data !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h exp deadbeef", r_data); end
        n_checks++; if (r_after !== 32'h0) begin n_fail++; $display("FAIL lw_rdata_clear: got %h exp 0", r_after); end
    endtask

    task automatic test_subword();
        run_req(0, 1'b1, 3'b000, 32'h102, 32'h0000_0055);
        n_checks++; if (r_lat !== 5) begin n_fail++; $display("FAIL sb_latency: got %0d exp 5", r_lat); end
        n_checks++; if (r_np !== 1) begin n_fail++; $display("FAIL sb_pulses: got %0d exp 1", r_np); end
        run_req(0, 1'b0, 3'b010, 32'h100, 32'h0);
        n_checks++; if (r_data !== 32'hDE55_BEEF) begin n_fail++; $display("FAIL sb_merge: got %h exp de55beef", r_data); end
        run_req(0, 1'b0, 3'b000, 32'h103, 32'h0);
        n_checks++; if (r_data !== 32'hFFFF_FFDE) begin n_fail++; $display("FAIL lb_sext: got %h exp ffffffde", r_data); end
        run_req(0, 1'b0, 3'b100, 32'h103, 32'h0);
        n_checks++; if (r_data !== 32'h0000_00DE) begin n_fail++; $display("FAIL lbu_zext: got %h exp 000000de", r_data); end
        run_req(0, 1'b0, 3'b001, 32'h102, 32'h0);
        n_checks++; if (r_data !== 32'hFFFF_DE55) begin n_fail++; $display("FAIL lh_upper: got %h exp ffffde55", r_data); end
        run_req(0, 1'b1, 3'b010, 32'h104, 32'h0);
        run_req(0, 1'b1, 3'b001, 32'h104, 32'hFFFF_8001);
        n_checks++; if (r_lat !== 5) begin n_fail++; $display("FAIL sh_latency: got %0d exp 5", r_lat); end
        run_req(0, 1'b0, 3'b001, 32'h104, 32'h0);
        n_checks++; if (r_data !== 32'hFFFF_8001) begin n_fail++; $display("FAIL lh_sext: got %h exp ffff8001", r_data); end
        run_req(0, 1'b0, 3'b101, 32'h104, 32'h0);
        n_checks++; if (r_data !== 32'h0000_8001) begin n_fail++; $display("FAIL lhu_zext: got %h exp 00008001", r_data); end
        run_req(0, 1'b1, 3'b001, 32'h106, 32'hABCD_1234);
        run_req(0, 1'b0, 3'b010, 32'h104, 32'h0);
        n_checks++; if (r_data !== 32'h1234_8001) begin n_fail++; $display("FAIL sh_upper_lane: got %h exp 12348001", r_data); end
    endtask

    task automatic test_errors();
        run_req(0, 1'b0, 3'b010, 32'h101, 32'h0);
        n_checks++; if (r_lat !== 1) begin n_fail++; $display("FAIL err_lw_latency: got %0d exp 1", r_lat); end
        n_checks++; if ({r_err, r_data} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL err_lw_resp: got err %b data %h exp 1/0", r_err, r_data); end
        run_req(0, 1'b1, 3'b100, 32'h100, 32'h0000_0077);
        n_checks++; if ({r_lat, r_err} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL err_sbu: got lat %0d err %b exp 1/1", r_lat, r_err); end
        run_req(0, 1'b0, 3'b011, 32'h100, 32'h0);
        n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL err_size011: got %b exp 1", r_err); end
        run_req(0, 1'b1, 3'b010, 32'h102, 32'h1111_1111);
        n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL err_sw_misaligned: got %b exp 1", r_err); end
        run_req(0, 1'b0, 3'b101, 32'h101, 32'h0);
        n_checks++; if (r_err !== 1'b1) begin n_fail++; $display("FAIL err_lhu_odd: got %b exp 1", r_err); end
        run_req(0, 1'b0, 3'b010, 32'h100, 32'h0);
        n_checks++; if ({r_err, r_data} !== {1'b0, 32'hDE55_BEEF}) begin n_fail++; $display("FAIL err_mem_untouched: got err %b data %h exp 0/de55beef", r_err, r_data); end
    endtask

    task automatic test_wrap();
        run_req(0, 1'b1, 3'b010, 32'h0010_0300, 32'hCAFE_F00D);
        run_req(0, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        n_checks++; if (r_data !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL addr_wrap: got %h exp cafef00d", r_data); end
    endtask

    task automatic test_handshake();
        int lows = 0, pulses = 0, rcyc = -1;
        logic ready5;
        @(negedge clk);
        req_we = 1'b0; req_size = 3'b010; req_addr = 32'h100; req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (!req_ready) lows++;
            if (resp_valid) begin pulses++; rcyc = c; end
        end
        @(negedge clk);
        ready5 = req_ready;
        req_valid = 1'b0;
        repeat (8) begin @(negedge clk); if (resp_valid) pulses++; end
        n_checks++; if (lows !== 4) begin n_fail++; $display("FAIL hs_ready_low: got %0d cycles exp 4", lows); end
        n_checks++; if (rcyc !== 4) begin n_fail++; $display("FAIL hs_resp_cycle: got %0d exp 4", rcyc); end
        n_checks++; if (ready5 !== 1'b1) begin n_fail++; $display("FAIL hs_ready_after: got %b exp 1", ready5); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL hs_pulses: got %0d exp 1", pulses); end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, first = -1, second = -1;
        logic [31:0] d1 = '0, d2 = '0;
        @(negedge clk);
        req_we = 1'b0; req_size = 3'b010; req_addr = 32'h104; req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (resp_valid) begin
                pulses++;
                if (first < 0) begin first = c; d1 = resp_rdata; end
                else begin second = c; d2 = resp_rdata; end
            end
        end
        req_valid = 1'b0;
        repeat (8) begin @(negedge clk); if (resp_valid) pulses++; end
        n_checks++; if ({first, second} !== {32'd4, 32'd9}) begin n_fail++; $display("FAIL b2b_cycles: got %0d,%0d exp 4,9", first, second); end
        n_checks++; if ({d1, d2} !== {32'h1234_8001, 32'h1234_8001}) begin n_fail++; $display("FAIL b2b_data: got %h,%h exp 12348001 twice", d1, d2); end
        n_checks++; if (pulses !== 2) begin n_fail++; $display("FAIL b2b_pulses: got %0d exp 2", pulses); end
    endtask

    task automatic test_w0();
        run_req(1, 1'b1, 3'b010, 32'h10, 32'h0BAD_F00D);
        n_checks++; if (r_lat !== 2) begin n_fail++; $display("FAIL w0_sw_latency: got %0d exp 2", r_lat); end
        run_req(1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_checks++; if ({r_lat, r_data} !== {32'd2, 32'h0BAD_F00D}) begin n_fail++; $display("FAIL w0_lw: got lat %0d data %h exp 2/0badf00d", r_lat, r_data); end
        run_req(1, 1'b1, 3'b000, 32'h11, 32'h0000_0099);
        n_checks++; if (r_lat !== 3) begin n_fail++; $display("FAIL w0_sb_latency: got %0d exp 3", r_lat); end
        run_req(1, 1'b0, 3'b010, 32'h10, 32'h0);
        n_checks++; if (r_data !== 32'h0BAD_990D) begin n_fail++; $display("FAIL w0_sb_merge: got %h exp 0bad990d", r_data); end
        run_req(1, 1'b0, 3'b001, 32'h11, 32'h0);
        n_checks++; if ({r_lat, r_err} !== {32'd1, 1'b1}) begin n_fail++; $display("FAIL w0_err: got lat %0d err %b exp 1/1", r_lat, r_err); end
    endtask

    // Start a store, assert reset at the negedge of cycle rcyc after accept, then release.
    task automatic reset_during(input logic [2:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input int rcyc, input string name);
        int pulses = 0;
        @(negedge clk);
        req_we = 1'b1; req_size = size; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (rcyc) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++; if ({req_ready, resp_valid, resp_err, resp_rdata} !== {3'b100, 32'h0}) begin
            n_fail++; $display("FAIL %s_outputs: got ready %b valid %b err %b rdata %h exp 1/0/0/0", name, req_ready, resp_valid, resp_err, resp_rdata);
        end
        @(posedge clk);
        @(negedge clk) reset = 1'b0;
        repeat (10) begin @(negedge clk); if (resp_valid) pulses++; end
        n_checks++; if (pulses !== 0) begin n_fail++; $display("FAIL %s_no_resp: got %0d pulses exp 0", name, pulses); end
    endtask

    task automatic test_reset_mid();
        run_req(0, 1'b1, 3'b010, 32'h200, 32'h1122_3344);
        reset_during(3'b000, 32'h200, 32'h0000_00AA, 1, "rst_wait");
        run_req(0, 1'b0, 3'b010, 32'h200, 32'h0);
        n_checks++; if (r_data !== 32'h1122_3344) begin n_fail++; $display("FAIL rst_wait_mem: got %h exp 11223344", r_data); end
        reset_during(3'b000, 32'h201, 32'h0000_00AA, 4, "rst_merge");
        run_req(0, 1'b0, 3'b010, 32'h200, 32'h0);
        n_checks++; if (r_data !== 32'h1122_3344) begin n_fail++; $display("FAIL rst_merge_mem: got %h exp 11223344", r_data); end
        reset_during(3'b000, 32'h202, 32'h0000_00BB, 5, "rst_resp");
        run_req(0, 1'b0, 3'b010, 32'h200, 32'h0);
        n_checks++; if (r_data !== 32'h11BB_3344) begin n_fail++; $display("FAIL rst_resp_mem: got %h exp 11bb3344", r_data); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_errors();
        test_wrap();
        test_handshake();
        test_back_to_back();
        test_w0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule
